// File: rtl/pipelined_csel_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_csel_adder
//  Description : Two-stage pipelined carry-select adder/subtractor with
//                valid/ready handshaking on both sides.
//                Stage 1 precomputes each block's sum and carry for a block
//                carry-in of 0 and of 1. Stage 2 ripples the selects from the
//                effective carry-in and registers sum, cout and ovf.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_csel_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLOCK;

  // Operand conditioning: subtract is a + ~b + ~borrow.
  logic [WIDTH-1:0] w_beff;
  logic             w_ceff;

  assign w_beff = sub ? ~b : b;
  assign w_ceff = sub ? ~cin : cin;

  // Per-block candidate results; each block is independent of its neighbours.
  logic [NBLK-1:0][BLOCK-1:0] w_cand0_sum;
  logic [NBLK-1:0][BLOCK-1:0] w_cand1_sum;
  logic [NBLK-1:0]            w_cand0_c;
  logic [NBLK-1:0]            w_cand1_c;

  generate
    for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
      assign {w_cand0_c[gi], w_cand0_sum[gi]} =
          {1'b0, a[gi*BLOCK +: BLOCK]} + {1'b0, w_beff[gi*BLOCK +: BLOCK]};
      assign {w_cand1_c[gi], w_cand1_sum[gi]} =
          {1'b0, a[gi*BLOCK +: BLOCK]} + {1'b0, w_beff[gi*BLOCK +: BLOCK]}
          + {{BLOCK{1'b0}}, 1'b1};
    end
  endgenerate

  // Handshake: a stage loads when empty or when its current beat moves on.
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s2_load;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign out_valid = r_s2_valid;

  // Stage 1 registers: both candidates per block plus sign information.
  logic [NBLK-1:0][BLOCK-1:0] r_s1_sum0;
  logic [NBLK-1:0][BLOCK-1:0] r_s1_sum1;
  logic [NBLK-1:0]            r_s1_c0;
  logic [NBLK-1:0]            r_s1_c1;
  logic                       r_s1_ceff;
  logic                       r_s1_amsb;
  logic                       r_s1_bmsb;

  // Stage 1: capture candidates on accept; valid follows in_valid whenever ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sum0  <= '0;
      r_s1_sum1  <= '0;
      r_s1_c0    <= '0;
      r_s1_c1    <= '0;
      r_s1_ceff  <= 1'b0;
      r_s1_amsb  <= 1'b0;
      r_s1_bmsb  <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sum0 <= w_cand0_sum;
        r_s1_sum1 <= w_cand1_sum;
        r_s1_c0   <= w_cand0_c;
        r_s1_c1   <= w_cand1_c;
        r_s1_ceff <= w_ceff;
        r_s1_amsb <= a[WIDTH-1];
        r_s1_bmsb <= w_beff[WIDTH-1];
      end
    end
  end

  // Stage 2 select chain: block 0 picks by the effective carry-in, each later
  // block by the carry selected for the block below it.
  logic [NBLK-1:0][BLOCK-1:0] w_sel_sum;
  logic                       w_carry;

  always_comb begin
    w_sel_sum = '0;
    w_carry   = r_s1_ceff;
    for (int i = 0; i < NBLK; i++) begin
      if (w_carry) begin
        w_sel_sum[i] = r_s1_sum1[i];
        w_carry      = r_s1_c1[i];
      end else begin
        w_sel_sum[i] = r_s1_sum0[i];
        w_carry      = r_s1_c0[i];
      end
    end
  end

  // Stage 2: register the result; hold it while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      sum        <= '0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        sum  <= w_sel_sum;
        cout <= w_carry;
        ovf  <= (r_s1_amsb == r_s1_bmsb) &&
                (w_sel_sum[NBLK-1][BLOCK-1] != r_s1_amsb);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_csel_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_csel_adder
//  Description : Self-checking bench. Three instances (8/4, 32/1, 64/8) share
//                handshake stimulus; an arithmetic reference model and a
//                scoreboard check every emitted beat, plus literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_csel_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;

  logic        in_ready8, in_ready32, in_ready64;
  logic        out_valid8, out_valid32, out_valid64;
  logic [7:0]  sum8;
  logic [31:0] sum32;
  logic [63:0] sum64;
  logic        cout8, cout32, cout64;
  logic        ovf8, ovf32, ovf64;

  always #5 clk = ~clk;

  pipelined_csel_adder #(.WIDTH(8), .BLOCK(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid8), .out_ready(out_ready),
    .sum(sum8), .cout(cout8), .ovf(ovf8));

  pipelined_csel_adder #(.WIDTH(32), .BLOCK(1)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid32), .out_ready(out_ready),
    .sum(sum32), .cout(cout32), .ovf(ovf32));

  pipelined_csel_adder #(.WIDTH(64), .BLOCK(8)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid64), .out_ready(out_ready),
    .sum(sum64), .cout(cout64), .ovf(ovf64));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
  } beat_t;

  beat_t      q[$];
  int         acc_cyc[$];
  int         out_cyc[$];
  logic [7:0] out_sum[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain arithmetic on the requirement's equations.
  function automatic void model(input logic [63:0] a_i, input logic [63:0] b_i,
                                input logic cin_i, input logic sub_i, input int w,
                                output logic [63:0] s, output logic co,
                                output logic ov);
    logic [64:0] mask;
    logic [64:0] total;
    logic [63:0] beff;
    logic        ceff;
    mask  = (65'd1 << w) - 65'd1;
    beff  = sub_i ? ~b_i : b_i;
    ceff  = sub_i ? ~cin_i : cin_i;
    total = ({1'b0, a_i} & mask) + ({1'b0, beff} & mask) + {64'd0, ceff};
    s     = total[63:0] & mask[63:0];
    co    = total[w];
    ov    = (a_i[w-1] == beff[w-1]) && (s[w-1] != a_i[w-1]);
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard / compare process, sampling on the falling edge.
  beat_t       m_bt;
  logic [63:0] m_s;
  logic        m_co, m_ov;
  logic        held_v = 1'b0;
  logic [7:0]  held_s8;
  logic [31:0] held_s32;
  logic [63:0] held_s64;
  logic [5:0]  held_f;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held_v = 1'b0;
    end else begin
      check("in_ready_agree", {63'd0, in_ready32 & in_ready64}, {63'd0, in_ready8});
      check("out_valid_agree", {63'd0, out_valid32 & out_valid64}, {63'd0, out_valid8});
      if (held_v) begin
        check("hold_sum8", {56'd0, sum8}, {56'd0, held_s8});
        check("hold_sum32", {32'd0, sum32}, {32'd0, held_s32});
        check("hold_sum64", sum64, held_s64);
        check("hold_flags", {58'd0, cout8, ovf8, cout32, ovf32, cout64, ovf64},
              {58'd0, held_f});
      end
      if (out_valid8 && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=sum %h expected=no beat", sum8);
        end else begin
          m_bt = q.pop_front();
          model(m_bt.a, m_bt.b, m_bt.cin, m_bt.sub, 8, m_s, m_co, m_ov);
          check("sum8", {56'd0, sum8}, m_s);
          check("flags8", {62'd0, cout8, ovf8}, {62'd0, m_co, m_ov});
          model(m_bt.a, m_bt.b, m_bt.cin, m_bt.sub, 32, m_s, m_co, m_ov);
          check("sum32", {32'd0, sum32}, m_s);
          check("flags32", {62'd0, cout32, ovf32}, {62'd0, m_co, m_ov});
          model(m_bt.a, m_bt.b, m_bt.cin, m_bt.sub, 64, m_s, m_co, m_ov);
          check("sum64", sum64, m_s);
          check("flags64", {62'd0, cout64, ovf64}, {62'd0, m_co, m_ov});
          out_sum.push_back(sum8);
          out_cyc.push_back(cyc);
        end
      end
      held_v = out_valid8 && !out_ready;
      if (held_v) begin
        held_s8  = sum8;
        held_s32 = sum32;
        held_s64 = sum64;
        held_f   = {cout8, ovf8, cout32, ovf32, cout64, ovf64};
      end
      if (in_valid && in_ready8) begin
        q.push_back('{a: a, b: b, cin: cin, sub: sub});
        acc_cyc.push_back(cyc);
      end
    end
  end

  // Offer one beat and return just after the edge that accepts it.
  task automatic send(input logic [63:0] a_i, input logic [63:0] b_i,
                      input logic cin_i, input logic sub_i);
    bit got = 0;
    a = a_i; b = b_i; cin = cin_i; sub = sub_i; in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready8) begin
        got = 1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready 0 expected=1");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  logic [63:0] p_s;
  logic        p_co, p_ov;
  int          idx;
  int          sent;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Model pinned against hand-computed values.
    model(64'hFF, 64'h01, 1'b0, 1'b0, 8, p_s, p_co, p_ov);
    check("model_ff_01", {p_s[62:0], p_co, p_ov} , {61'h0, 3'b010} );
    model(64'h7F, 64'h01, 1'b0, 1'b0, 8, p_s, p_co, p_ov);
    check("model_7f_01", {p_s[61:0], p_co, p_ov}, {54'd0, 8'h80, 2'b01});
    model(64'h05, 64'h07, 1'b0, 1'b1, 8, p_s, p_co, p_ov);
    check("model_5_m7", {p_s[61:0], p_co, p_ov}, {54'd0, 8'hFE, 2'b00});

    // Asynchronous reset state before any clock edge.
    #1;
    check("rst_out_valid", {63'd0, out_valid8}, 64'd0);
    check("rst_outputs", {54'd0, sum8, cout8, ovf8}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", {63'd0, in_ready8}, 64'd1);

    // Carry-out wrap, two-cycle latency.
    send(64'hFF, 64'h01, 1'b0, 1'b0);
    check("lat_n1_not_valid", {63'd0, out_valid8}, 64'd0);
    @(posedge clk); #1;
    check("lat_n2_valid", {63'd0, out_valid8}, 64'd1);
    check("ff01_result", {54'd0, sum8, cout8, ovf8}, {54'd0, 8'h00, 2'b10});

    send(64'h7F, 64'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("7f01_result", {54'd0, sum8, cout8, ovf8}, {54'd0, 8'h80, 2'b01});
    send(64'h05, 64'h07, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("5m7_result", {54'd0, sum8, cout8, ovf8}, {54'd0, 8'hFE, 2'b00});
    drain();

    // Back-to-back stream i+i.
    acc_cyc.delete(); out_cyc.delete(); out_sum.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = 64'(i); b = 64'(i); cin = 1'b0; sub = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (in_ready8) break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    check("stream_count", 64'(out_sum.size()), 64'd10);
    for (int j = 0; j < 10 && j < out_sum.size(); j++) begin
      check("stream_value", {56'd0, out_sum[j]}, 64'(2 * j));
      check("stream_cycle", 64'(out_cyc[j]), 64'(acc_cyc[0] + 2 + j));
    end

    // Backpressure: three beats, output stalled for four cycles.
    out_sum.delete();
    out_ready = 1'b0;
    idx = 0;
    for (int t = 0; t < 4; t++) begin
      in_valid = (idx < 3);
      a = 64'h10 + 64'(idx); b = 64'h01; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready8) idx++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("stall_accepts", 64'(idx), 64'd2);
    check("stall_in_ready", {63'd0, in_ready8}, 64'd0);
    check("stall_out_valid", {63'd0, out_valid8}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && idx < 3; t++) begin
      in_valid = 1'b1;
      a = 64'h10 + 64'(idx);
      @(negedge clk);
      if (in_ready8) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    check("stall_count", 64'(out_sum.size()), 64'd3);
    for (int j = 0; j < 3 && j < out_sum.size(); j++)
      check("stall_order", {56'd0, out_sum[j]}, 64'h11 + 64'(j));

    // Reset with two beats in flight.
    send(64'h21, 64'h01, 1'b0, 1'b0);
    send(64'h22, 64'h01, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid8}, 64'd0);
    check("midrst_outputs", {54'd0, sum8, cout8, ovf8}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_sum.delete();
    repeat (5) @(posedge clk);
    #1;
    check("no_stale_out", 64'(out_sum.size()), 64'd0);
    check("no_stale_valid", {63'd0, out_valid8}, 64'd0);

    // Random operands with random valid / ready.
    sent = 0;
    for (int t = 0; t < 4000 && sent < 300; t++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      cin = $urandom_range(1);
      sub = $urandom_range(1);
      @(negedge clk);
      if (in_valid && in_ready8) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("random_sent", 64'(sent), 64'd300);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
